simmem_release_scheduler: RTL

Delay-driven release scheduler for one response bank (write-response or read-data) of the simulated memory controller. Accepts a reservation notice per internal identifier (iid) with a response delay and the AXI ID, then counts each slot's delay down. It raises the bank's multi-hot release enable once the delay has elapsed and all older same-ID slots are released, which preserves AXI per-ID ordering. The bank's released-address one-hot frees the slot. One instance sits between the delay calculator and each bank.

---
 rtl/simmem_pkg.sv | 15 +
 rtl/simmem_release_slot.sv | 63 ++++++
 rtl/simmem_release_scheduler.sv | 83 ++++++++
 3 files changed

// File: rtl/simmem_pkg.sv
// Shared parameters and types for the simulated memory controller.
// Holds bank capacities, ID count, release-delay width and slot states.
package simmem_pkg;

  localparam int unsigned WRspBankCapa = 4;
  localparam int unsigned NumIds = 4;
  localparam int unsigned RelDelayW = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ARMED = 2'd2
  } rel_slot_state_e;

endpackage

// File: rtl/simmem_release_slot.sv
// One release slot: holds state, delay counter and AXI ID of a reservation.
// Ports: clk/rst, enq (accepted notice), delay, new_id, rel (slot freed),
// armed/active status and the stored one-hot id.
module simmem_release_slot #(
  parameter int unsigned NumIds = simmem_pkg::NumIds,
  parameter int unsigned DelayW = simmem_pkg::RelDelayW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq,
  input  logic [DelayW-1:0] delay,
  input  logic [NumIds-1:0] new_id,
  input  logic              rel,
  output logic              armed,
  output logic              active,
  output logic [NumIds-1:0] id
);

  simmem_pkg::rel_slot_state_e state_q, state_d;
  logic [DelayW-1:0] cnt_q, cnt_d;
  logic [NumIds-1:0] id_q, id_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= simmem_pkg::IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    case (state_q)
      simmem_pkg::IDLE: begin
        if (enq) begin
          state_d = simmem_pkg::COUNT;
          cnt_d   = delay;
          id_d    = new_id;
        end
      end
      simmem_pkg::COUNT: begin
        if (cnt_q == '0) state_d = simmem_pkg::ARMED;
        else cnt_d = cnt_q - DelayW'(1);
      end
      simmem_pkg::ARMED: begin
        if (rel) state_d = simmem_pkg::IDLE;
      end
      default: state_d = simmem_pkg::IDLE;
    endcase
  end

  assign armed  = (state_q == simmem_pkg::ARMED);
  assign active = (state_q == simmem_pkg::COUNT) ||
                  (state_q == simmem_pkg::ARMED);
  assign id     = id_q;

endmodule

// File: rtl/simmem_release_scheduler.sv
// Delay-driven release scheduler for one response bank, keeping AXI per-ID
// order. Ports: enq_* reservation notice, release_en_o releasable slots,
// released_addr_onehot_i freed slots, active_o occupancy, err_o sticky error.
module simmem_release_scheduler #(
  parameter int unsigned NumSlots = simmem_pkg::WRspBankCapa,
  parameter int unsigned NumIds   = simmem_pkg::NumIds,
  parameter int unsigned DelayW   = simmem_pkg::RelDelayW
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enq_valid_i,
  output logic                enq_ready_o,
  input  logic [NumSlots-1:0] enq_iid_onehot_i,
  input  logic [NumIds-1:0]   enq_id_onehot_i,
  input  logic [DelayW-1:0]   enq_delay_i,
  output logic [NumSlots-1:0] release_en_o,
  input  logic [NumSlots-1:0] released_addr_onehot_i,
  output logic [NumSlots-1:0] active_o,
  output logic                err_o
);

  logic [NumSlots-1:0] armed, active, same_id;
  logic [NumSlots-1:0] enq_fire, rel_fire;
  logic [NumSlots-1:0][NumIds-1:0] slot_id;
  // older_q[i][j]: slot j holds an earlier same-ID response than slot i
  logic [NumSlots-1:0][NumSlots-1:0] older_q;
  logic req_ok, bad, err_q;

  assign req_ok = $onehot(enq_iid_onehot_i) && $onehot(enq_id_onehot_i);
  assign enq_ready_o = req_ok && (|(enq_iid_onehot_i & ~active));
  assign enq_fire = (enq_valid_i && enq_ready_o) ? enq_iid_onehot_i : '0;
  assign rel_fire = released_addr_onehot_i & release_en_o;

  for (genvar g = 0; g < NumSlots; g++) begin : g_slot
    simmem_release_slot #(
      .NumIds(NumIds),
      .DelayW(DelayW)
    ) u_slot (
      .clk   (clk_i),
      .rst   (rst_i),
      .enq   (enq_fire[g]),
      .delay (enq_delay_i),
      .new_id(enq_id_onehot_i),
      .rel   (rel_fire[g]),
      .armed (armed[g]),
      .active(active[g]),
      .id    (slot_id[g])
    );
  end

  always_comb begin
    same_id      = '0;
    release_en_o = '0;
    for (int i = 0; i < NumSlots; i++) begin
      same_id[i] = active[i] & (|(slot_id[i] & enq_id_onehot_i));
      release_en_o[i] = armed[i] & ~(|older_q[i]);
    end
  end

  // A same-cycle release is excluded from the new row so no stale bit remains
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      older_q <= '0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (enq_fire[i]) older_q[i] <= same_id & ~rel_fire;
        else older_q[i] <= older_q[i] & ~rel_fire;
      end
    end
  end

  assign bad = (enq_valid_i && !req_ok) ||
               (|(released_addr_onehot_i & ~release_en_o));

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else if (bad) err_q <= 1'b1;
  end

  assign active_o = active;
  assign err_o    = err_q;

endmodule
